// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared types and defaults for the multi-port register file.
//   rf_state_t      : clear-engine state (RF_CLEAR zeroes the array, RF_IDLE
//                     accepts writes)
//   RF_DATA_W_DEF   : default register width
//   RF_NUM_REGS_DEF : default register count (top index is the PC slot)
//   rf_pc_idx(n)    : index of the PC slot in an n-entry file
// -----------------------------------------------------------------------------
package rf_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W_DEF   = 32;
    localparam int RF_NUM_REGS_DEF = 16;

    function automatic int rf_pc_idx(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// -----------------------------------------------------------------------------
// rf_clear_fsm
// Clear engine and write gating for register_file_mp. After reset, or on
// clear_req, it walks clr_cnt from 0 to NUM_REGS-2 writing zero into each
// general register, then settles in IDLE where normal writes are permitted.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear_req_i  : request to re-run the clear sequence
//   wr_any_i     : a non-PC write is being requested this cycle
//   clr_we_o     : array must write zero at clr_addr_o this cycle
//   clr_addr_o   : index being cleared
//   wr_ok_o      : normal writes may update the array this cycle
//   ready_o      : registered, high while in IDLE
//   wr_drop_o    : registered pulse, a write was discarded last cycle
// -----------------------------------------------------------------------------
module rf_clear_fsm
    import rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req_i,
    input  logic              wr_any_i,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              wr_ok_o,
    output logic              ready_o,
    output logic              wr_drop_o
);

    // The last general register; the PC slot above it has no storage.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 2);

    rf_state_t         state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              ready_q;
    logic              wr_drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RF_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            // A write is lost if the engine is clearing or a clear is being
            // requested in the same cycle.
            wr_drop_q <= wr_any_i && ((state_q == RF_CLEAR) || clear_req_i);
            case (state_q)
                RF_CLEAR: begin
                    if (clear_req_i) begin
                        clr_cnt_q <= '0;
                    end else if (clr_cnt_q == LAST_IDX) begin
                        state_q   <= RF_IDLE;
                        ready_q   <= 1'b1;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                RF_IDLE: begin
                    if (clear_req_i) begin
                        state_q   <= RF_CLEAR;
                        ready_q   <= 1'b0;
                        clr_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q   <= RF_CLEAR;
                    ready_q   <= 1'b0;
                    clr_cnt_q <= '0;
                end
            endcase
        end
    end

    assign clr_we_o   = (state_q == RF_CLEAR);
    assign clr_addr_o = clr_cnt_q;
    assign wr_ok_o    = (state_q == RF_IDLE) && !clear_req_i;
    assign ready_o    = ready_q;
    assign wr_drop_o  = wr_drop_q;

endmodule

// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
// Parametrised register file: NUM_RD combinational read ports, two write
// ports (port 1 = load writeback, higher priority), PC supplied externally
// at index NUM_REGS-1, and a sequential clear engine (rf_clear_fsm).
//
// Build option: define RF_BYPASS_EN to forward same-cycle write data to
// reads in IDLE (port 1 over port 0). Without it reads see the stored value.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   ra / rd           : packed read addresses / data, port k at slice k
//   we0, wa0, wd0     : write port 0 (ALU result)
//   we1, wa1, wd1     : write port 1 (load data)
//   pc_in             : value returned for reads of the PC index
//   clear_req         : request to zero all general registers
//   ready             : high in IDLE (writes accepted)
//   wr_drop           : registered pulse, a write was discarded last cycle
// -----------------------------------------------------------------------------
module register_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int NUM_REGS = RF_NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic                     clear_req,
    output logic                     ready,
    output logic                     wr_drop
);

    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(rf_pc_idx(NUM_REGS));

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    logic              wr_any;
    logic              wr0_q_en;
    logic              wr1_q_en;

    // Entry PC_IDX is never written; reads of it are served from pc_in.
    logic [DATA_W-1:0] mem_q [NUM_REGS];

    // PC-targeted writes are ignored silently, so they never count as drops.
    assign wr0_q_en = we0 && (wa0 != PC_IDX);
    assign wr1_q_en = we1 && (wa1 != PC_IDX);
    assign wr_any   = wr0_q_en || wr1_q_en;

    rf_clear_fsm #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clear_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_req_i (clear_req),
        .wr_any_i    (wr_any),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr),
        .wr_ok_o     (wr_ok),
        .ready_o     (ready),
        .wr_drop_o   (wr_drop)
    );

    // Storage is deliberately not reset; the clear engine zeroes it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (clr_we && (clr_addr == ADDR_W'(i))) begin
                mem_q[i] <= '0;
            end else if (wr_ok && wr1_q_en && (wa1 == ADDR_W'(i))) begin
                mem_q[i] <= wd1;
            end else if (wr_ok && wr0_q_en && (wa0 == ADDR_W'(i))) begin
                mem_q[i] <= wd0;
            end
        end
    end

    logic [ADDR_W-1:0] rd_addr;

    always_comb begin
        rd      = '0;
        rd_addr = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr = ra[k*ADDR_W +: ADDR_W];
            if (rd_addr == PC_IDX) begin
                rd[k*DATA_W +: DATA_W] = pc_in;
            end else if (!ready) begin
                rd[k*DATA_W +: DATA_W] = '0;
`ifdef RF_BYPASS_EN
            end else if (wr_ok && wr1_q_en && (wa1 == rd_addr)) begin
                rd[k*DATA_W +: DATA_W] = wd1;
            end else if (wr_ok && wr0_q_en && (wa0 == rd_addr)) begin
                rd[k*DATA_W +: DATA_W] = wd0;
`endif
            end else begin
                rd[k*DATA_W +: DATA_W] = mem_q[rd_addr];
            end
        end
    end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the processor datapath. It generalises the 16×32, 2-read/1-write file to a configurable width, depth and read-port count, with a second write port for load writeback and an externally supplied PC at the top index. A sequential clear engine zeroes the array after reset or on request. Reads are combinational and write-to-read forwarding is optional. Sits between decode (read addresses) and writeback (write ports).

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 16, register count; top index is the PC slot
- ADDR_W, $clog2(NUM_REGS), address width
- NUM_RD, 2, number of read ports (1..4)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- ra  in  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd  out  NUM_RD*DATA_W  packed read data, same packing
- we0 / wa0 / wd0  in  1 / ADDR_W / DATA_W  write port 0 (ALU result)
- we1 / wa1 / wd1  in  1 / ADDR_W / DATA_W  write port 1 (load data), higher priority
- pc_in  in  DATA_W  value returned for reads of index NUM_REGS-1
- clear_req  in  1  single-cycle request to zero all general registers
- ready  out  1  high when the file is in IDLE and accepting writes
- wr_drop  out  1  registered pulse: a write was discarded in the previous cycle

## Operation
- State machine CLEAR / IDLE. The state reset value is CLEAR with clr_cnt=0, ready=0, wr_drop=0.
- Array storage is not reset; it is zeroed by the clear engine instead.
- CLEAR: each cycle writes 0 to reg[clr_cnt] and increments clr_cnt. After writing index NUM_REGS-2, the FSM moves to IDLE.
- IDLE: clear_req moves the FSM to CLEAR with clr_cnt=0.
- clear_req asserted while in CLEAR restarts clr_cnt at 0.
- Writes in IDLE: reg[wa0]←wd0 if we0; reg[wa1]←wd1 if we1. If wa0==wa1 with both enabled, port 1 wins.
- Writes to index NUM_REGS-1 (PC) are ignored silently and do not raise wr_drop.
- Writes during CLEAR, or in the same cycle as clear_req in IDLE, are discarded. wr_drop=1 on the next cycle, for one cycle per offending cycle.
- Reads: rd[k] = pc_in when ra[k]==NUM_REGS-1.
- Other reads in CLEAR state return 0.
- Other reads in IDLE return the stored value, subject to forwarding (see Configuration).

## Timing
- Read latency 0 (combinational on ra, array and pc_in). Write latency 1 edge.
- After rst_n rises, ready goes high at the (NUM_REGS-1)th rising edge (15 with defaults).
- After a clear_req edge in IDLE, ready is low for NUM_REGS-1 cycles, then high.
- Reset asserted mid-clear or mid-write aborts immediately: the FSM returns to CLEAR with clr_cnt=0, and the partially written array is cleared again.
- clr_cnt is ADDR_W bits wide; it never wraps, because the FSM exits at NUM_REGS-2.

## Configuration
- RF_BYPASS_EN defined: in IDLE, a read of an address being written this cycle returns the incoming write data. Port 1 data takes priority over port 0 when both target that address.
- RF_BYPASS_EN undefined: such a read returns the old stored value, and the new value is visible from the next cycle.
- PC and CLEAR-state read rules apply in both builds.

## Structure
- Package rf_pkg holds:
  - the rf_state_t enum {RF_CLEAR, RF_IDLE}
  - localparam RF_DATA_W_DEF=32 and RF_NUM_REGS_DEF=16
  - the rf_pc_idx(n) function, which returns n-1
- Sub-module rf_clear_fsm owns the state, clr_cnt, ready and wr_drop. It outputs clr_we, clr_addr and a write-permit signal to the array logic.

## Test plan
- Reset release with clear_req=0 → ready=0 for 14 cycles and 1 on edge 15. During that time, reads of r1 return 0 and reads of r15 return pc_in=0x4C.
- IDLE: we0, wa0=1, wd0=0xC; next cycle ra0=1 → rd0=0xC. In the same cycle, ra1=15 → rd1=0x4C.
- Dual write to r4: we0 wd0=0x8 and we1 wd1=0xC25 → r4=0xC25 next cycle. With RF_BYPASS_EN, a same-cycle read of r4 returns 0xC25; without it, the read returns the old value.
- Write r14=0xC25, then clear_req → ready low 15 cycles. A write to r3=0x7 during CLEAR → wr_drop pulses one cycle later. After ready, r3=0 and r14=0.
- Write to r15=0xFFFF in IDLE → reads of r15 still return pc_in, and wr_drop stays 0.
- rst_n pulsed low at clr_cnt=7 during a clear → the FSM restarts and ready rises 15 edges after release.
